// File: rtl/mips_load_pkg.sv
// Shared types for the MIPS load/writeback slice: load type and FSM state
// encodings plus the alignment rule for the naturally aligned load types.
package mips_load_pkg;

  typedef enum logic [2:0] {
    LT_LB      = 3'd0,
    LT_LBU     = 3'd1,
    LT_LH      = 3'd2,
    LT_LHU     = 3'd3,
    LT_LW      = 3'd4,
    LT_LWL     = 3'd5,
    LT_LWR     = 3'd6,
    LT_ILLEGAL = 3'd7
  } load_type_e;

  localparam logic [2:0] LOAD_TYPE_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // LWL/LWR are byte-granular and never misaligned; legality of those is decided elsewhere.
  function automatic logic is_misaligned(load_type_e t, logic [1:0] k);
    logic bad;
    case (t)
      LT_LH, LT_LHU: bad = k[0];
      LT_LW:         bad = |k;
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Combinational byte/halfword extraction and LWL/LWR merge of a little-endian
// memory word with the old rt value.
module mips_load_align
  import mips_load_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  k,
  input  logic [31:0] word,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;
  logic [31:0] lwl_merge;
  logic [31:0] lwr_merge;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte  = lane[k];
  assign sel_half  = k[1] ? word[31:16] : word[15:0];
  assign lwl_shift = {2'd3 - k, 3'b000};
  assign lwr_shift = {k, 3'b000};
  // LWL keeps the low bytes of rt below the loaded bytes; LWR keeps the high bytes.
  assign lwl_merge = (word << lwl_shift) | (rt_old & ((32'd1 << lwl_shift) - 32'd1));
  assign lwr_merge = (word >> lwr_shift) | (rt_old & ~(32'hFFFF_FFFF >> lwr_shift));

  always_comb begin
    data = 32'd0;
    case (load_type_e'(load_type))
      LT_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  data = {24'd0, sel_byte};
      LT_LH:   data = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  data = {16'd0, sel_half};
      LT_LW:   data = word;
      LT_LWL:  data = lwl_merge;
      LT_LWR:  data = lwr_merge;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mips_load_writeback.sv
// Register-file write port driver: load handshake FSM plus a one-entry ALU skid buffer.
// MIPS_UNALIGNED_LOAD_EN enables LWL/LWR; otherwise they are rejected as illegal types.
module mips_load_writeback
  import mips_load_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [2:0]  load_type,
  input  logic [31:0] load_addr,
  input  logic [4:0]  load_dest,
  input  logic [31:0] rt_old,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_result,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        write_enable,
  output logic [4:0]  write_register,
  output logic [31:0] write_data,
  output logic        load_error
);

  state_e      state_q, state_d;
  load_type_e  type_q, type_d;
  logic [1:0]  k_q, k_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        alu_buf_full_q, alu_buf_full_d;
  logic [4:0]  alu_buf_dest_q, alu_buf_dest_d;
  logic [31:0] alu_buf_data_q, alu_buf_data_d;
  logic        load_ready_q, load_ready_d;
  logic        alu_ready_q, alu_ready_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        write_enable_q, write_enable_d;
  logic [4:0]  write_register_q, write_register_d;
  logic [31:0] write_data_q, write_data_d;
  logic        load_error_q, load_error_d;

  load_type_e  req_type;
  logic        load_accept;
  logic        alu_accept;
  logic        load_bad;
  logic        load_wb_next;
  logic        stall_timeout;
  logic [31:0] aligned_data;

  assign req_type      = load_type_e'(load_type);
  assign load_accept   = load_valid & load_ready_q;
  assign alu_accept    = alu_valid & alu_ready_q;
  assign stall_timeout = (TIMEOUT != 0) && ((stall_cnt_q + 32'd1) == TIMEOUT);

  always_comb begin
    load_bad = is_misaligned(req_type, load_addr[1:0]);
    if (load_type == LOAD_TYPE_ILLEGAL) begin
      load_bad = 1'b1;
    end
`ifdef MIPS_UNALIGNED_LOAD_EN
`else
    if (req_type == LT_LWL || req_type == LT_LWR) begin
      load_bad = 1'b1;
    end
`endif
  end

  mips_load_align u_align (
    .load_type (type_q),
    .k         (k_q),
    .word      (mem_readdata),
    .rt_old    (rt_old_q),
    .data      (aligned_data)
  );

  always_comb begin
    state_d          = state_q;
    type_d           = type_q;
    k_d              = k_q;
    dest_d           = dest_q;
    rt_old_d         = rt_old_q;
    stall_cnt_d      = stall_cnt_q;
    alu_buf_full_d   = alu_buf_full_q;
    alu_buf_dest_d   = alu_buf_dest_q;
    alu_buf_data_d   = alu_buf_data_q;
    load_ready_d     = load_ready_q;
    mem_read_d       = mem_read_q;
    mem_address_d    = mem_address_q;
    write_enable_d   = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    load_error_d     = 1'b0;
    load_wb_next     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_accept) begin
          type_d        = req_type;
          k_d           = load_addr[1:0];
          dest_d        = load_dest;
          rt_old_d      = rt_old;
          mem_address_d = {load_addr[31:2], 2'b00};
          stall_cnt_d   = 32'd0;
          load_ready_d  = 1'b0;
          if (load_bad) begin
            state_d      = ST_WB;
            load_error_d = 1'b1;
            load_wb_next = 1'b1;
          end else begin
            state_d    = ST_REQ;
            mem_read_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (!mem_waitrequest) begin
          state_d          = ST_WB;
          mem_read_d       = 1'b0;
          load_wb_next     = 1'b1;
          write_enable_d   = (dest_q != 5'd0);
          write_register_d = dest_q;
          write_data_d     = aligned_data;
        end else if (stall_timeout) begin
          state_d      = ST_WB;
          mem_read_d   = 1'b0;
          load_error_d = 1'b1;
          load_wb_next = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
      end
      ST_WB: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b1;
      end
      default: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b1;
        mem_read_d   = 1'b0;
      end
    endcase

    // The load owns the write port in its WB cycle; an ALU result arriving then waits one cycle.
    if (!load_wb_next) begin
      if (alu_buf_full_q) begin
        alu_buf_full_d   = 1'b0;
        write_enable_d   = (alu_buf_dest_q != 5'd0);
        write_register_d = alu_buf_dest_q;
        write_data_d     = alu_buf_data_q;
      end else if (alu_accept) begin
        write_enable_d   = (alu_dest != 5'd0);
        write_register_d = alu_dest;
        write_data_d     = alu_result;
      end
    end else if (alu_accept) begin
      alu_buf_full_d = 1'b1;
      alu_buf_dest_d = alu_dest;
      alu_buf_data_d = alu_result;
    end
    alu_ready_d = ~alu_buf_full_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      type_q           <= LT_LB;
      k_q              <= 2'd0;
      dest_q           <= 5'd0;
      rt_old_q         <= 32'd0;
      stall_cnt_q      <= 32'd0;
      alu_buf_full_q   <= 1'b0;
      alu_buf_dest_q   <= 5'd0;
      alu_buf_data_q   <= 32'd0;
      load_ready_q     <= 1'b1;
      alu_ready_q      <= 1'b1;
      mem_read_q       <= 1'b0;
      mem_address_q    <= 32'd0;
      write_enable_q   <= 1'b0;
      write_register_q <= 5'd0;
      write_data_q     <= 32'd0;
      load_error_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      type_q           <= type_d;
      k_q              <= k_d;
      dest_q           <= dest_d;
      rt_old_q         <= rt_old_d;
      stall_cnt_q      <= stall_cnt_d;
      alu_buf_full_q   <= alu_buf_full_d;
      alu_buf_dest_q   <= alu_buf_dest_d;
      alu_buf_data_q   <= alu_buf_data_d;
      load_ready_q     <= load_ready_d;
      alu_ready_q      <= alu_ready_d;
      mem_read_q       <= mem_read_d;
      mem_address_q    <= mem_address_d;
      write_enable_q   <= write_enable_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      load_error_q     <= load_error_d;
    end
  end

  assign load_ready     = load_ready_q;
  assign alu_ready      = alu_ready_q;
  assign mem_read       = mem_read_q;
  assign mem_address    = mem_address_q;
  assign write_enable   = write_enable_q;
  assign write_register = write_register_q;
  assign write_data     = write_data_q;
  assign load_error     = load_error_q;

endmodule

// File: tb/tb_mips_load_writeback.sv
// Bench for mips_load_writeback: a cycle-indexed schedule of expected outputs is
// built from each accepted transaction and compared against the DUT every cycle.
module tb_mips_load_writeback;

  localparam int TO = 16;
  localparam int N  = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [2:0]  load_type;
  logic [31:0] load_addr;
  logic [4:0]  load_dest;
  logic [31:0] rt_old;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_result;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        write_enable;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        load_error;

  mips_load_writeback #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_type       (load_type),
    .load_addr       (load_addr),
    .load_dest       (load_dest),
    .rt_old          (rt_old),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_dest        (alu_dest),
    .alu_result      (alu_result),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .write_enable    (write_enable),
    .write_register  (write_register),
    .write_data      (write_data),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle, plus memory-side stimulus per cycle.
  logic        exp_lr [N];
  logic        exp_ar [N];
  logic        exp_mr [N];
  logic        exp_we [N];
  logic        exp_err[N];
  logic        exp_wb [N];
  logic [31:0] exp_addr [N];
  logic [31:0] exp_wdata[N];
  logic [4:0]  exp_wreg [N];
  logic        drv_wait [N];
  logic [31:0] drv_rdata[N];

  int   n_chk = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;
  int   last_acc = 0;
  logic last_acc_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", name, cyc, act, want);
    end
  endtask

  function automatic logic [31:0] model_extract(input int t, input logic [31:0] a,
                                                input logic [31:0] rd, input logic [31:0] rt);
    longint w, r, b, h, p;
    int k;
    w = longint'(rd);
    r = longint'(rt);
    k = int'(a % 4);
    b = (w >> (8 * k)) % 256;
    h = (w >> (16 * (k / 2))) % 65536;
    case (t)
      0: return (b >= 128) ? 32'(b - 256) : 32'(b);
      1: return 32'(b);
      2: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3: return 32'(h);
      4: return rd;
      5: begin
        p = longint'(1) << (8 * (3 - k));
        return 32'(((w * p) % (longint'(1) << 32)) + (r % p));
      end
      6: begin
        p = longint'(1) << (8 * k);
        return 32'((w / p) + (r - (r % ((longint'(1) << 32) / p))));
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_bad(input int t, input logic [31:0] a);
    if (t == 7) return 1'b1;
`ifdef MIPS_UNALIGNED_LOAD_EN
    if (t == 5 || t == 6) return 1'b0;
`else
    if (t == 5 || t == 6) return 1'b1;
`endif
    if ((t == 2 || t == 3) && (a % 2) != 0) return 1'b1;
    if (t == 4 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_from(input int from);
    for (int i = from; i < N; i++) begin
      exp_lr[i] = 1'b1;  exp_ar[i] = 1'b1;  exp_mr[i] = 1'b0;
      exp_we[i] = 1'b0;  exp_err[i] = 1'b0; exp_wb[i] = 1'b0;
      exp_addr[i] = 32'd0; exp_wdata[i] = 32'd0; exp_wreg[i] = 5'd0;
      drv_wait[i]  = 1'($urandom % 2);
      drv_rdata[i] = $urandom;
    end
  endtask

  task automatic sched_load(input int c, input int lt, input logic [31:0] la, input logic [4:0] ld,
                            input logic [31:0] rt, input int stalls, input logic [31:0] rd);
    int w;
    if (model_bad(lt, la)) begin
      w = c + 1;
      exp_err[w] = 1'b1;
      $display("load  c=%0d type=%0d addr=%08h dest=%0d -> rejected", c, lt, la, ld);
    end else if (stalls >= TO) begin
      for (int i = c + 1; i <= c + TO; i++) begin
        exp_mr[i] = 1'b1; exp_addr[i] = {la[31:2], 2'b00}; drv_wait[i] = 1'b1;
      end
      w = c + TO + 1;
      exp_err[w] = 1'b1;
      $display("load  c=%0d type=%0d addr=%08h dest=%0d stalls=%0d -> timeout", c, lt, la, ld, stalls);
    end else begin
      for (int i = c + 1; i <= c + 1 + stalls; i++) begin
        exp_mr[i] = 1'b1; exp_addr[i] = {la[31:2], 2'b00}; drv_wait[i] = 1'b1;
      end
      drv_wait[c + 1 + stalls]  = 1'b0;
      drv_rdata[c + 1 + stalls] = rd;
      w = c + 2 + stalls;
      if (ld != 5'd0) begin
        exp_we[w] = 1'b1; exp_wreg[w] = ld; exp_wdata[w] = model_extract(lt, la, rd, rt);
      end
      $display("load  c=%0d type=%0d addr=%08h dest=%0d stalls=%0d rd=%08h -> r%0d=%08h at %0d",
               c, lt, la, ld, stalls, rd, ld, model_extract(lt, la, rd, rt), w);
    end
    exp_wb[w] = 1'b1;
    for (int i = c + 1; i <= w; i++) exp_lr[i] = 1'b0;
  endtask

  task automatic sched_alu(input int c, input logic [4:0] ad, input logic [31:0] ar);
    int t;
    t = exp_wb[c + 1] ? c + 2 : c + 1;
    if (t == c + 2) exp_ar[c + 1] = 1'b0;
    if (ad != 5'd0) begin
      exp_we[t] = 1'b1; exp_wreg[t] = ad; exp_wdata[t] = ar;
    end
    $display("alu   c=%0d r%0d=%08h at %0d", c, ad, ar, t);
  endtask

  task automatic step(input logic lv, input logic [2:0] lt, input logic [31:0] la, input logic [4:0] ld,
                      input logic [31:0] rt, input int stalls, input logic [31:0] rd,
                      input logic av, input logic [4:0] ad, input logic [31:0] ar);
    @(negedge clk);
    load_valid = lv; load_type = lt; load_addr = la; load_dest = ld; rt_old = rt;
    alu_valid = av; alu_dest = ad; alu_result = ar;
    last_acc_ok = 1'b0;
    if (lv && exp_lr[cyc]) begin
      sched_load(cyc, int'(lt), la, ld, rt, stalls, rd);
      last_acc = cyc;
      last_acc_ok = 1'b1;
    end
    if (av && exp_ar[cyc]) sched_alu(cyc, ad, ar);
    mem_waitrequest = drv_wait[cyc];
    mem_readdata    = drv_rdata[cyc];
  endtask

  task automatic step_idle();
    step(1'b0, 3'd0, 32'd0, 5'd0, 32'd0, 0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wait_load_ready();
    int guard = 0;
    while (!exp_lr[cyc + 1] && guard < 100) begin
      step_idle();
      guard++;
    end
    if (guard >= 100) chk("wait_load_ready", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_alu_ready"}, 32'(alu_ready), 32'd1);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_write_enable"}, 32'(write_enable), 32'd0);
    chk({tag, "_write_register"}, 32'(write_register), 32'd0);
    chk({tag, "_write_data"}, write_data, 32'd0);
    chk({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  // Single compare process: every checked cycle against the expected schedule.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("load_ready", 32'(load_ready), 32'(exp_lr[cyc]));
      chk("alu_ready", 32'(alu_ready), 32'(exp_ar[cyc]));
      chk("mem_read", 32'(mem_read), 32'(exp_mr[cyc]));
      chk("write_enable", 32'(write_enable), 32'(exp_we[cyc]));
      chk("load_error", 32'(load_error), 32'(exp_err[cyc]));
      if (exp_mr[cyc]) chk("mem_address", mem_address, exp_addr[cyc]);
      if (exp_we[cyc]) begin
        chk("write_register", 32'(write_register), 32'(exp_wreg[cyc]));
        chk("write_data", write_data, exp_wdata[cyc]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int lt, stl;
    logic [4:0] ld;
    clear_from(0);
    reset = 1'b0;
    load_valid = 1'b0; load_type = 3'd0; load_addr = 32'd0; load_dest = 5'd0; rt_old = 32'd0;
    alu_valid = 1'b0; alu_dest = 5'd0; alu_result = 32'd0;
    mem_waitrequest = 1'b0; mem_readdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    clear_from(cyc);
    @(posedge clk);
    #1 chk_en = 1'b1;
    step_idle();

    // Model pins: hand-computed extraction results.
    chk("pin_lb", model_extract(0, 32'h3, 32'h80FF_1234, 32'd0), 32'hFFFF_FF80);
    chk("pin_lhu", model_extract(3, 32'h2, 32'hBEEF_0000, 32'd0), 32'h0000_BEEF);
    chk("pin_lh", model_extract(2, 32'h2, 32'h8000_1234, 32'd0), 32'hFFFF_8000);
    chk("pin_lwl", model_extract(5, 32'h1, 32'h1122_3344, 32'hAABB_CCDD), 32'h3344_CCDD);
    chk("pin_lwr", model_extract(6, 32'h1, 32'h1122_3344, 32'hAABB_CCDD), 32'hAA11_2233);

    // 1: LB sign-extended, latency 2.
    wait_load_ready();
    step(1'b1, 3'd0, 32'h1000_0003, 5'd8, 32'd0, 0, 32'h80FF_1234, 1'b0, 5'd0, 32'd0);
    c = last_acc;
    chk("t1_accepted", 32'(last_acc_ok), 32'd1);
    chk("t1_model_wdata", exp_wdata[c + 2], 32'hFFFF_FF80);
    repeat (4) step_idle();

    // 2: LHU with 3 stall cycles, latency 5.
    wait_load_ready();
    step(1'b1, 3'd3, 32'h2000_0002, 5'd9, 32'd0, 3, 32'hBEEF_0000, 1'b0, 5'd0, 32'd0);
    c = last_acc;
    chk("t2_model_we", 32'(exp_we[c + 5]), 32'd1);
    chk("t2_model_wdata", exp_wdata[c + 5], 32'h0000_BEEF);
    repeat (7) step_idle();

    // 3: misaligned LW.
    wait_load_ready();
    step(1'b1, 3'd4, 32'h3000_0001, 5'd10, 32'd0, 0, 32'd0, 1'b0, 5'd0, 32'd0);
    c = last_acc;
    chk("t3_model_err", 32'(exp_err[c + 1]), 32'd1);
    chk("t3_model_mr", 32'(exp_mr[c + 1]), 32'd0);
    repeat (3) step_idle();

    // 4: ALU result collides with the load WB cycle.
    wait_load_ready();
    step(1'b1, 3'd4, 32'h4000_0000, 5'd6, 32'd0, 0, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0);
    c = last_acc;
    step(1'b0, 3'd0, 32'd0, 5'd0, 32'd0, 0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    chk("t4_model_alu_ready", 32'(exp_ar[c + 2]), 32'd0);
    chk("t4_model_reg", 32'(exp_wreg[c + 3]), 32'd5);
    chk("t4_model_data", exp_wdata[c + 3], 32'h0000_1234);
    repeat (4) step_idle();

    // 5: load into r0 never writes.
    wait_load_ready();
    step(1'b1, 3'd4, 32'h5000_0000, 5'd0, 32'd0, 0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    c = last_acc;
    chk("t5_model_we", 32'(exp_we[c + 2]), 32'd0);
    chk("t5_model_ready", 32'(exp_lr[c + 3]), 32'd1);
    repeat (4) step_idle();

    // 6: waitrequest timeout.
    wait_load_ready();
    step(1'b1, 3'd4, 32'h6000_0000, 5'd11, 32'd0, TO, 32'd0, 1'b0, 5'd0, 32'd0);
    c = last_acc;
    chk("t6_model_mr_last", 32'(exp_mr[c + TO]), 32'd1);
    chk("t6_model_mr_drop", 32'(exp_mr[c + TO + 1]), 32'd0);
    chk("t6_model_err", 32'(exp_err[c + TO + 1]), 32'd1);
    repeat (TO + 4) step_idle();

    // 6b: reset in the middle of a stalled request.
    wait_load_ready();
    step(1'b1, 3'd4, 32'h7000_0000, 5'd12, 32'd0, 8, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    repeat (3) step_idle();
    @(posedge clk);
    #1 chk_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0; alu_valid = 1'b0; mem_waitrequest = 1'b1;
    @(negedge clk);
    chk("t6b_mem_read", 32'(mem_read), 32'd0);
    chk("t6b_write_enable", 32'(write_enable), 32'd0);
    chk("t6b_load_ready", 32'(load_ready), 32'd1);
    chk("t6b_alu_ready", 32'(alu_ready), 32'd1);
    chk("t6b_load_error", 32'(load_error), 32'd0);
    reset = 1'b1;
    clear_from(cyc);
    @(posedge clk);
    #1 chk_en = 1'b1;
    step_idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if (cyc > N - 64) break;
      lt = int'($urandom % 8);
      case ($urandom % 10)
        0, 1, 2, 3, 4, 5: stl = int'($urandom % 3);
        6, 7, 8:          stl = 3 + int'($urandom % 4);
        default:          stl = TO - 2 + int'($urandom % 4);
      endcase
      ld = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom % 32);
      step(1'($urandom % 3 == 0), 3'(lt), $urandom, ld, $urandom, stl, $urandom,
           1'($urandom % 3 == 0), ($urandom % 2 == 0) ? ld : 5'($urandom % 32), $urandom);
    end
    repeat (TO + 8) step_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
